// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
//   state_t : run-control FSM encoding (IDLE, RUN, PAUSE, OVF)
//   BCD_W   : bits per decade digit
//   BCD_MAX : highest value a decade digit holds before wrapping
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVF   = 2'd3
    } state_t;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

endpackage

// File: rtl/stopwatch_ctrl_decade_digit.sv
// One decade (mod-10) digit of the stopwatch count.
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   clr    : synchronous clear to 0 (dominates en)
//   en     : advance by one this edge; 9 wraps to 0
//   q      : current digit value, 0..9
//   at_max : high while q == 9, feeds the carry chain
module decade_digit
    import stopwatch_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             at_max
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            if (at_max) begin
                q <= '0;
            end else begin
                q <= q + BCD_W'(1);
            end
        end
    end

    assign at_max = (q == BCD_W'(BCD_MAX));

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear BCD stopwatch: prescaler, run-control FSM and the
// carry chain enabling a cascade of decade digits.
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   start_stop : single-cycle pulse, toggles run/pause
//   clear      : single-cycle pulse, back to zero/idle (highest priority)
//   bcd        : packed BCD count, digit 0 in bits [3:0]
//   running    : high while in RUN
//   overflow   : high while in OVF
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | count at zero, prescaler at zero, waiting for start_stop
// RUN   | prescaler advancing, digits advance on each tick
// PAUSE | count and prescaler frozen, start_stop resumes
// OVF   | tick seen at all-9s; count saturated, only clear/reset leave
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start_stop,
    input  logic                      clear,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      running,
    output logic                      overflow
);

    localparam int              PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    state_t             state;
    state_t             state_next;
    logic [PSC_W-1:0]   psc;
    logic [PSC_W-1:0]   psc_next;
    logic               tick;
    logic               all_max;
    logic               en_base;
    logic [DIGITS-1:0]  at_max;
    logic [DIGITS-1:0]  en;

    assign all_max = &at_max;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            psc      <= '0;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            psc      <= psc_next;
            running  <= (state_next == RUN);
            overflow <= (state_next == OVF);
        end
    end

    always_comb begin
        state_next = state;
        psc_next   = psc;
        tick       = 1'b0;
        if (clear) begin
            state_next = IDLE;
            psc_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    psc_next = '0;
                    if (start_stop) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    // A pause request on the wrap edge wins: no tick, and the
                    // prescaler keeps PSC_LAST so resume ticks on the next edge.
                    if (start_stop) begin
                        state_next = PAUSE;
                    end else if (psc == PSC_LAST) begin
                        psc_next = '0;
                        tick     = 1'b1;
                        if (all_max) begin
                            state_next = OVF;
                        end
                    end else begin
                        psc_next = psc + PSC_W'(1);
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_next = RUN;
                    end
                end
                OVF: begin
                    psc_next = '0;
                end
                default: begin
                    state_next = IDLE;
                    psc_next   = '0;
                end
            endcase
        end
    end

    // Gating the whole chain at all-9s makes the count saturate instead of
    // wrapping to zero on the overflow tick.
    assign en_base = tick & ~all_max;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            if (k == 0) begin : g_lsd
                assign en[k] = en_base;
            end else begin : g_upper
                assign en[k] = en_base & (&at_max[k-1:0]);
            end

            decade_digit u_digit (
                .clock  (clock),
                .reset  (reset),
                .clr    (clear),
                .en     (en[k]),
                .q      (bcd[k*BCD_W +: BCD_W]),
                .at_max (at_max[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl.
// Main instance: DIGITS=2, PRESCALE=2. Second instance: DIGITS=2, PRESCALE=1.
// Inputs driven and outputs sampled on the falling edge.
module tb_stopwatch_ctrl;

    logic       clock;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic [7:0] bcd;
    logic       running;
    logic       overflow;

    logic       start_stop1;
    logic       clear1;
    logic [7:0] bcd1;
    logic       running1;
    logic       overflow1;

    int n_checks;
    int n_errors;

    stopwatch_ctrl #(.DIGITS(2), .PRESCALE(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .bcd        (bcd),
        .running    (running),
        .overflow   (overflow)
    );

    stopwatch_ctrl #(.DIGITS(2), .PRESCALE(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .start_stop (start_stop1),
        .clear      (clear1),
        .bcd        (bcd1),
        .running    (running1),
        .overflow   (overflow1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Returns half a cycle after n more rising edges.
    task automatic wait_edges(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Pulse sampled at the next rising edge E; returns half a cycle after E.
    task automatic pulse_start();
        start_stop = 1'b1;
        @(negedge clock);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #100;
        reset = 1'b0;
        n_checks++;
        if (bcd !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_bcd: got %h want 00", bcd);
        end
        n_checks++;
        if (running !== 1'b0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: running=%b overflow=%b want 0 0", running, overflow);
        end
        wait_edges(10);
        n_checks++;
        if (bcd !== 8'h00 || running !== 1'b0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_hold: bcd=%h running=%b overflow=%b want 00 0 0",
                     bcd, running, overflow);
        end
    endtask

    task automatic test_count();
        pulse_start();                       // edge E
        n_checks++;
        if (running !== 1'b1 || bcd !== 8'h00) begin
            n_errors++;
            $display("FAIL count_start: running=%b bcd=%h want 1 00", running, bcd);
        end
        wait_edges(1);                       // E+1: no tick yet
        n_checks++;
        if (bcd !== 8'h00) begin
            n_errors++;
            $display("FAIL count_e1: got %h want 00", bcd);
        end
        wait_edges(1);                       // E+2: first tick
        n_checks++;
        if (bcd !== 8'h01) begin
            n_errors++;
            $display("FAIL count_e2: got %h want 01", bcd);
        end
        wait_edges(16);                      // E+18
        n_checks++;
        if (bcd !== 8'h09) begin
            n_errors++;
            $display("FAIL count_e18: got %h want 09", bcd);
        end
        wait_edges(2);                       // E+20: digit carry
        n_checks++;
        if (bcd !== 8'h10) begin
            n_errors++;
            $display("FAIL count_carry: got %h want 10", bcd);
        end
        pulse_clear();
        n_checks++;
        if (bcd !== 8'h00 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL count_clear: bcd=%h running=%b want 00 0", bcd, running);
        end
    endtask

    task automatic test_pause_resume();
        pulse_start();                       // E
        wait_edges(2);                       // E+2: bcd=01, prescaler=0
        pulse_start();                       // E+3: pause, prescaler held at 0
        n_checks++;
        if (bcd !== 8'h01 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL pause: bcd=%h running=%b want 01 0", bcd, running);
        end
        wait_edges(10);
        n_checks++;
        if (bcd !== 8'h01) begin
            n_errors++;
            $display("FAIL pause_hold: got %h want 01", bcd);
        end
        pulse_start();                       // R: resume
        n_checks++;
        if (running !== 1'b1 || bcd !== 8'h01) begin
            n_errors++;
            $display("FAIL resume: running=%b bcd=%h want 1 01", running, bcd);
        end
        wait_edges(1);                       // R+1: prescaler 0->1
        n_checks++;
        if (bcd !== 8'h01) begin
            n_errors++;
            $display("FAIL resume_r1: got %h want 01", bcd);
        end
        wait_edges(1);                       // R+2: tick
        n_checks++;
        if (bcd !== 8'h02) begin
            n_errors++;
            $display("FAIL resume_r2: got %h want 02", bcd);
        end
        pulse_clear();
    endtask

    task automatic test_priority();
        pulse_start();                       // E
        wait_edges(3);                       // E+3: bcd=01
        start_stop = 1'b1;
        clear      = 1'b1;
        @(negedge clock);
        start_stop = 1'b0;
        clear      = 1'b0;
        n_checks++;
        if (bcd !== 8'h00 || running !== 1'b0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL prio_clear: bcd=%h running=%b overflow=%b want 00 0 0",
                     bcd, running, overflow);
        end
        wait_edges(3);
        n_checks++;
        if (bcd !== 8'h00 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL prio_idle_hold: bcd=%h running=%b want 00 0", bcd, running);
        end
        pulse_start();                       // E
        wait_edges(1);                       // E+1: prescaler=1
        pulse_start();                       // E+2 would tick: pause wins
        n_checks++;
        if (bcd !== 8'h00 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL prio_tick_pause: bcd=%h running=%b want 00 0", bcd, running);
        end
        wait_edges(4);
        pulse_start();                       // R: resume, prescaler still 1
        n_checks++;
        if (bcd !== 8'h00) begin
            n_errors++;
            $display("FAIL prio_resume_edge: got %h want 00", bcd);
        end
        wait_edges(1);                       // R+1: held tick fires
        n_checks++;
        if (bcd !== 8'h01) begin
            n_errors++;
            $display("FAIL prio_resume_tick: got %h want 01", bcd);
        end
        pulse_clear();
    endtask

    task automatic test_overflow();
        pulse_start();                       // E
        wait_edges(197);                     // E+197
        n_checks++;
        if (bcd !== 8'h98) begin
            n_errors++;
            $display("FAIL ovf_e197: got %h want 98", bcd);
        end
        wait_edges(1);                       // E+198
        n_checks++;
        if (bcd !== 8'h99 || running !== 1'b1 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_e198: bcd=%h running=%b overflow=%b want 99 1 0",
                     bcd, running, overflow);
        end
        wait_edges(2);                       // E+200: tick at all-9s
        n_checks++;
        if (bcd !== 8'h99 || running !== 1'b0 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_enter: bcd=%h running=%b overflow=%b want 99 0 1",
                     bcd, running, overflow);
        end
        pulse_start();
        wait_edges(5);
        n_checks++;
        if (bcd !== 8'h99 || running !== 1'b0 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_ignore_start: bcd=%h running=%b overflow=%b want 99 0 1",
                     bcd, running, overflow);
        end
        pulse_clear();
        n_checks++;
        if (bcd !== 8'h00 || running !== 1'b0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clear: bcd=%h running=%b overflow=%b want 00 0 0",
                     bcd, running, overflow);
        end
        pulse_start();                       // IDLE again: start works
        n_checks++;
        if (running !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_restart: running=%b want 1", running);
        end
        pulse_clear();
    endtask

    task automatic test_async_reset();
        pulse_start();                       // E
        wait_edges(74);                      // 37 ticks
        n_checks++;
        if (bcd !== 8'h37) begin
            n_errors++;
            $display("FAIL async_pre: got %h want 37", bcd);
        end
        #2;
        reset = 1'b1;
        #1;                                  // still before the next rising edge
        n_checks++;
        if (bcd !== 8'h00 || running !== 1'b0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: bcd=%h running=%b overflow=%b want 00 0 0",
                     bcd, running, overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        wait_edges(3);
        n_checks++;
        if (bcd !== 8'h00 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL async_after: bcd=%h running=%b want 00 0", bcd, running);
        end
    endtask

    task automatic test_prescale1();
        clear1 = 1'b1;
        @(negedge clock);
        clear1 = 1'b0;
        start_stop1 = 1'b1;
        @(negedge clock);                    // E
        start_stop1 = 1'b0;
        n_checks++;
        if (running1 !== 1'b1 || bcd1 !== 8'h00) begin
            n_errors++;
            $display("FAIL p1_start: running=%b bcd=%h want 1 00", running1, bcd1);
        end
        wait_edges(1);
        n_checks++;
        if (bcd1 !== 8'h01) begin
            n_errors++;
            $display("FAIL p1_e1: got %h want 01", bcd1);
        end
        wait_edges(1);
        n_checks++;
        if (bcd1 !== 8'h02) begin
            n_errors++;
            $display("FAIL p1_e2: got %h want 02", bcd1);
        end
        wait_edges(9);
        n_checks++;
        if (bcd1 !== 8'h11) begin
            n_errors++;
            $display("FAIL p1_e11: got %h want 11", bcd1);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        start_stop  = 1'b0;
        clear       = 1'b0;
        start_stop1 = 1'b0;
        clear1      = 1'b0;
        reset       = 1'b1;
        test_reset();
        test_count();
        test_pause_resume();
        test_priority();
        test_overflow();
        test_async_reset();
        test_prescale1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
